tinker_mem_responder: RTL and testbench

Memory-side responder for the Tinker core's request interface. It holds the unified byte-addressed, little-endian instruction/data store. It serves 32-bit instruction fetches and 64-bit data loads/stores (including the call/return stack traffic) through a req/valid handshake with a programmable access latency. It sits between the core's fetch/ALU address outputs and the storage array, and arbitrates the fetch and data ports onto one array.

---
 rtl/tinker_mem_responder.sv | 146 ++++++++++++++
 tb/tb_tinker_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_mem_responder.sv
// Unified little-endian instruction/data store for the Tinker core: one request
// in flight, data port wins arbitration, response after a programmable wait.
module tinker_mem_responder #(
  parameter int MEM_BYTES = 524288,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_valid,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic        lat_d;
  logic        lat_we;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;

  logic [7:0]  mem [0:MEM_BYTES-1];

  logic        accept;
  logic        sel_d;
  logic        sel_we;
  logic [63:0] sel_addr;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [63:0] rd_word;

  // In IDLE the live request is used so LATENCY=0 can respond on the next edge;
  // afterwards only the latched request matters.
  always_comb begin
    accept   = (state == IDLE) && (d_req || if_req);
    sel_d    = lat_d;
    sel_we   = lat_we;
    sel_addr = lat_addr;
    if (state == IDLE) begin
      sel_d    = d_req;
      sel_we   = d_req & d_we;
      sel_addr = d_req ? d_addr : if_addr;
    end else begin
      sel_d    = lat_d;
    end
    in_range = (({1'b0, sel_addr} + (sel_d ? 65'd7 : 65'd3)) < 65'(MEM_BYTES));
    idx      = sel_addr[AW-1:0];
    rd_word  = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[idx + AW'(i)];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (LATENCY > 0) ? WAIT : RESP;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered off next_state so they line up with the RESP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_d     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 64'd0;
      lat_wdata <= 64'd0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      if_rdata  <= 32'd0;
      d_rdata   <= 64'd0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      if (accept) begin
        lat_d     <= sel_d;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= d_wdata;
        cnt       <= 4'(LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (next_state == RESP) begin
        if_valid <= ~sel_d;
        d_valid  <= sel_d;
        err      <= ~in_range;
        if (sel_d) begin
          d_rdata <= (in_range && !sel_we) ? rd_word : 64'd0;
        end else begin
          if_rdata <= in_range ? rd_word[31:0] : 32'd0;
        end
      end else begin
        if_valid <= 1'b0;
        d_valid  <= 1'b0;
        err      <= 1'b0;
      end
    end
  end

  // Stores commit on the edge leaving RESP; reset or a range error cancels them.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && lat_d && lat_we && in_range) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + AW'(i)] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Table-driven scoreboard bench for tinker_mem_responder (LATENCY=2 instance)
// plus a LATENCY=0 instance for back-to-back throughput.
module tb_tinker_mem_responder;

  localparam int LAT = 2;
  localparam int MB  = 524288;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, if_valid, d_req, d_we, d_valid, err, busy;
  logic [63:0] if_addr, d_addr, d_wdata, d_rdata;
  logic [31:0] if_rdata;

  logic        z_if_req, z_if_valid, z_d_req, z_d_we, z_d_valid, z_err, z_busy;
  logic [63:0] z_if_addr, z_d_addr, z_d_wdata, z_d_rdata;
  logic [31:0] z_if_rdata;

  tinker_mem_responder #(.MEM_BYTES(MB), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err), .busy(busy)
  );

  tinker_mem_responder #(.MEM_BYTES(MB), .LATENCY(0)) dut_z (
    .clk(clk), .reset(reset),
    .if_req(z_if_req), .if_addr(z_if_addr), .if_rdata(z_if_rdata), .if_valid(z_if_valid),
    .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_rdata(z_d_rdata), .d_valid(z_d_valid), .err(z_err), .busy(z_busy)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Returns cycles until the selected valid is seen at a falling edge, -1 on timeout.
  task automatic wait_valid(input logic is_d, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      seen = is_d ? d_valid : if_valid;
    end
    if (!seen) n = -1;
  endtask

  task automatic check_resp(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb actual=response required=empty_queue", name);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("%s_dvalid", name), {63'd0, d_valid}, {63'd0, e.is_d});
      chk($sformatf("%s_ifvalid", name), {63'd0, if_valid}, {63'd0, ~e.is_d});
      chk($sformatf("%s_rdata", name), e.is_d ? d_rdata : {32'd0, if_rdata}, e.rdata);
      chk($sformatf("%s_err", name), {63'd0, err}, {63'd0, e.err});
    end
  endtask

  task automatic run_req(input vec_t v, input string name);
    int n;
    @(negedge clk);
    sbq.push_back('{v.is_d, v.exp_rdata, v.exp_err});
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    wait_valid(v.is_d, n);
    chk($sformatf("%s_latency", name), 64'(n), 64'(LAT + 1));
    check_resp(name);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_pulse", name), {62'd0, d_valid, if_valid}, 64'd0);
    chk($sformatf("%s_hold", name), v.is_d ? d_rdata : {32'd0, if_rdata}, v.exp_rdata);
  endtask

  initial begin
    int n;
    int vcount;
    reset = 1'b1;
    if_req = 1'b0; if_addr = 64'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0;
    z_if_req = 1'b0; z_if_addr = 64'd0; z_d_req = 1'b0; z_d_we = 1'b0; z_d_addr = 64'd0; z_d_wdata = 64'd0;
    for (int i = 0; i < MB; i++) begin
      dut.mem[i] = 8'h00;
      dut_z.mem[i] = 8'h00;
    end
    dut.mem[32'h2000] = 8'h78; dut.mem[32'h2001] = 8'h56;
    dut.mem[32'h2002] = 8'h34; dut.mem[32'h2003] = 8'h12;
    for (int i = 0; i < 16; i++) dut.mem[32'h100 + i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) dut.mem[32'h300 + i] = 8'hAA;
    for (int i = 0; i < 24; i++) dut_z.mem[32'h40 + i] = 8'(32'h40 + i);

    vecs[0]  = '{1'b0, 1'b0, 64'h2000,             64'h0,                 64'h12345678,          1'b0};
    vecs[1]  = '{1'b1, 1'b1, 64'h7FFF8,            64'h1122334455667788,  64'h0,                 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 64'h7FFF8,            64'h0,                 64'h1122334455667788,  1'b0};
    vecs[3]  = '{1'b1, 1'b0, 64'h7FFFC,            64'h0,                 64'h0,                 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'hA5A5A5A5A5A5A5A5,  64'h0,                 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 64'h7FFFC,            64'h0,                 64'h11223344,          1'b0};
    vecs[6]  = '{1'b1, 1'b0, 64'h101,              64'h0,                 64'h0908070605040302,  1'b0};
    vecs[7]  = '{1'b1, 1'b1, 64'h103,              64'hDEADBEEFCAFEF00D,  64'h0,                 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 64'h100,              64'h0,                 64'hEFCAFEF00D030201,  1'b0};
    vecs[9]  = '{1'b0, 1'b0, 64'h105,              64'h0,                 64'hBEEFCAFE,          1'b0};
    vecs[10] = '{1'b1, 1'b0, 64'h7FFF9,            64'h0,                 64'h0,                 1'b1};
    vecs[11] = '{1'b0, 1'b0, 64'h7FFFD,            64'h0,                 64'h0,                 1'b1};
    vecs[12] = '{1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFE, 64'h0,                 64'h0,                 1'b1};
    vecs[13] = '{1'b1, 1'b0, 64'h7FFF8,            64'h0,                 64'h1122334455667788,  1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_outs", {60'd0, if_valid, d_valid, err, busy}, 64'd0);
    chk("rst_if_rdata", {32'd0, if_rdata}, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_mem_keep", {56'd0, dut.mem[32'h2000]}, 64'h78);

    for (int i = 0; i < 14; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    chk("mem_7fff8", {56'd0, dut.mem[32'h7FFF8]}, 64'h88);
    chk("mem_wrap_keep", {32'd0, dut.mem[32'h7FFFF], dut.mem[32'h7FFFE], dut.mem[32'h7FFFD], dut.mem[32'h7FFFC]}, 64'h11223344);

    // Both ports in one cycle: data first, fetch LATENCY+2 cycles after d_valid.
    @(negedge clk);
    sbq.push_back('{1'b1, 64'hEFCAFEF00D030201, 1'b0});
    sbq.push_back('{1'b0, 64'h12345678, 1'b0});
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
    if_req = 1'b1; if_addr = 64'h2000;
    wait_valid(1'b1, n);
    chk("arb_d_latency", 64'(n), 64'(LAT + 1));
    check_resp("arb_d");
    @(posedge clk);
    #1 d_req = 1'b0;
    wait_valid(1'b0, n);
    chk("arb_if_gap", 64'(n + 1), 64'(LAT + 2));
    check_resp("arb_if");
    @(posedge clk);
    #1 if_req = 1'b0;

    // Store aborted by reset while waiting.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h300; d_wdata = 64'h0102030405060708;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_wait", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    d_req = 1'b0;
    chk("abort_idle", {61'd0, busy, d_valid, err}, 64'd0);
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (d_valid || if_valid) vcount++;
    end
    chk("abort_no_valid", 64'(vcount), 64'd0);
    chk("abort_mem_keep", {dut.mem[32'h307], dut.mem[32'h306], dut.mem[32'h305], dut.mem[32'h304],
                           dut.mem[32'h303], dut.mem[32'h302], dut.mem[32'h301], dut.mem[32'h300]},
        64'hAAAAAAAAAAAAAAAA);
    run_req(vecs[0], "post_rst_fetch");

    // LATENCY=0: requester keeps req high and retargets it on each valid edge.
    @(negedge clk);
    z_d_req = 1'b1; z_d_addr = 64'h40;
    for (int k = 0; k < 3; k++) begin
      bit seen;
      logic [63:0] exp_word;
      seen = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(posedge clk);
        @(negedge clk);
        n++;
        seen = z_d_valid;
      end
      for (int b = 0; b < 8; b++) exp_word[8*b +: 8] = 8'(32'h40 + 8*k + b);
      chk($sformatf("z_b2b%0d_cycles", k), 64'(seen ? n : -1), 64'd1);
      chk($sformatf("z_b2b%0d_rdata", k), z_d_rdata, exp_word);
      chk($sformatf("z_b2b%0d_err", k), {63'd0, z_err}, 64'd0);
      @(posedge clk);
      #1;
      z_d_addr = 64'h40 + 64'(8 * (k + 1));
      if (k == 2) z_d_req = 1'b0;
    end
    @(negedge clk);
    chk("z_idle", {62'd0, z_busy, z_d_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
